// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane geometry for the MEM stage and its byte-enabled data memory.
package mem_stage_pkg;

  localparam int MEM_DWL = 32;
  localparam int NLANE   = MEM_DWL / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/dmem_bytewise.sv
// Byte-enabled data RAM: asynchronous read, synchronous per-lane write, shared address.
module dmem_bytewise
  import mem_stage_pkg::*;
#(
  parameter int AWL   = 6,
  parameter int DWL   = 32,
  parameter int DEPTH = 2**AWL
) (
  input  logic             CLK,
  input  logic             WE,
  input  logic [NLANE-1:0] BE,
  input  logic [AWL-1:0]   WA,
  input  logic [DWL-1:0]   WD,
  output logic [DWL-1:0]   RD
);

  logic [DWL-1:0] memQ [DEPTH];

  // Contents deliberately have no reset; only enabled lanes are touched.
  always_ff @(posedge CLK) begin
    if (WE) begin
      for (int l = 0; l < NLANE; l++) begin
        if (BE[l]) memQ[WA][8*l +: 8] <= WD[8*l +: 8];
      end
    end
  end

  assign RD = memQ[WA];

endmodule

// File: rtl/memory_stage_bw.sv
// Pipelined MEM stage: sub-word load/store steering, extension, misalignment check and MEM/WB register.
module memory_stage_bw
  import mem_stage_pkg::*;
#(
  parameter int AWL   = 6,
  parameter int DWL   = 32,
  parameter int DEPTH = 2**AWL,
  parameter int RFAWL = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             RFWEM,
  input  logic             MtoRFSelM,
  input  logic             DMWEM,
  input  logic [1:0]       MemSizeM,
  input  logic             MemSignedM,
  input  logic [DWL-1:0]   ALUOutM,
  input  logic [DWL-1:0]   DMdinM,
  input  logic [RFAWL-1:0] RFAM,
  output logic             RFWEW,
  output logic             MtoRFSelW,
  output logic [DWL-1:0]   DMOutW,
  output logic [DWL-1:0]   ALUOutW,
  output logic [RFAWL-1:0] RFAW,
  output logic             MisalignW
);

  generate
    if (DWL != MEM_DWL) begin : gUnsupportedWidth
      $error("memory_stage_bw supports only DWL = 32");
    end
  endgenerate

  logic [1:0]       lane;
  logic             isByte;
  logic             isHalf;
  logic             misaligned;
  logic             MisalignM;
  logic             memWe;
  logic [NLANE-1:0] be;
  logic [DWL-1:0]   wd;
  logic [DWL-1:0]   rdWord;
  logic [7:0]       byteVal;
  logic [15:0]      halfVal;
  logic [DWL-1:0]   loadData;

  assign lane   = ALUOutM[1:0];
  assign isByte = (MemSizeM == SZ_BYTE);
  assign isHalf = (MemSizeM == SZ_HALF);

  // Reserved size 2'b11 falls through to the word rules.
  always_comb begin
    misaligned = 1'b0;
    if (isHalf)       misaligned = lane[0];
    else if (!isByte) misaligned = |lane;
  end

  assign MisalignM = (DMWEM | MtoRFSelM) & misaligned;
  assign memWe     = DMWEM & ~MisalignM;

  // Store data arrives right-aligned; replicate it so every candidate lane sees it.
  always_comb begin
    be = '1;
    wd = DMdinM;
    if (isByte) begin
      be       = '0;
      be[lane] = 1'b1;
      wd       = {NLANE{DMdinM[7:0]}};
    end else if (isHalf) begin
      be = lane[1] ? 4'b1100 : 4'b0011;
      wd = {2{DMdinM[15:0]}};
    end
  end

  dmem_bytewise #(
    .AWL   (AWL),
    .DWL   (DWL),
    .DEPTH (DEPTH)
  ) uDmem (
    .CLK (CLK),
    .WE  (memWe),
    .BE  (be),
    .WA  (ALUOutM[AWL+1:2]),
    .WD  (wd),
    .RD  (rdWord)
  );

  assign byteVal = rdWord[{lane, 3'b000} +: 8];
  assign halfVal = lane[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    loadData = rdWord;
    if (MisalignM)   loadData = '0;
    else if (isByte) loadData = {{24{MemSignedM & byteVal[7]}}, byteVal};
    else if (isHalf) loadData = {{16{MemSignedM & halfVal[15]}}, halfVal};
  end

  logic             rfweD,   rfweQ;
  logic             mtorfD,  mtorfQ;
  logic             misD,    misQ;
  logic [DWL-1:0]   dmOutD,  dmOutQ;
  logic [DWL-1:0]   aluOutD, aluOutQ;
  logic [RFAWL-1:0] rfaD,    rfaQ;

  // Flush outranks stall; reset is handled asynchronously in the register below.
  always_comb begin
    rfweD   = rfweQ;
    mtorfD  = mtorfQ;
    misD    = misQ;
    dmOutD  = dmOutQ;
    aluOutD = aluOutQ;
    rfaD    = rfaQ;
    if (FlushW) begin
      rfweD   = 1'b0;
      mtorfD  = 1'b0;
      misD    = 1'b0;
      dmOutD  = '0;
      aluOutD = '0;
      rfaD    = '0;
    end else if (!StallW) begin
      rfweD   = RFWEM & ~MisalignM;
      mtorfD  = MtoRFSelM;
      misD    = MisalignM;
      dmOutD  = loadData;
      aluOutD = ALUOutM;
      rfaD    = RFAM;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rfweQ   <= 1'b0;
      mtorfQ  <= 1'b0;
      misQ    <= 1'b0;
      dmOutQ  <= '0;
      aluOutQ <= '0;
      rfaQ    <= '0;
    end else begin
      rfweQ   <= rfweD;
      mtorfQ  <= mtorfD;
      misQ    <= misD;
      dmOutQ  <= dmOutD;
      aluOutQ <= aluOutD;
      rfaQ    <= rfaD;
    end
  end

  assign RFWEW     = rfweQ;
  assign MtoRFSelW = mtorfQ;
  assign MisalignW = misQ;
  assign DMOutW    = dmOutQ;
  assign ALUOutW   = aluOutQ;
  assign RFAW      = rfaQ;

endmodule
